// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, parity selectors and the parity helper.
package uart_pkg;
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP1  = 3'd4;
  localparam logic [2:0] STOP2  = 3'd5;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE   = IDLE,
    S_START  = START,
    S_DATA   = DATA,
    S_PARITY = PARITY,
    S_STOP1  = STOP1,
    S_STOP2  = STOP2
  } uart_state_e;

  // Callers zero-extend the data word; the extra zeros do not affect the XOR.
  function automatic logic par_bit(input logic [15:0] d, input logic typ);
    return (^d) ^ (typ == PAR_ODD);
  endfunction
endpackage

// File: rtl/uart_tx_shreg.sv
// TX data shift register with data-bit counter; dout is the next bit to put on the line.
module uart_tx_shreg
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load,
  input  logic                  shift,
  input  logic                  first,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  dout,
  output logic                  last
);
  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] sr;
  logic [CW-1:0]         cnt;

  // The first shift happens when the start bit ends, so cnt tracks the bit on the line.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sr  <= '0;
      cnt <= '0;
    end else if (load) begin
      sr  <= din;
      cnt <= '0;
    end else if (shift) begin
      sr  <= sr >> 1;
      cnt <= first ? '0 : cnt + 1'b1;
    end
  end

  assign dout = sr[0];
  assign last = (cnt == LAST_IDX);
endmodule

// File: rtl/uart_tx_ctrl_p.sv
// UART transmit controller: valid/accept capture, LSB-first serialisation,
// optional parity, one or two stop bits, back-to-back frames paced by TICK.
module uart_tx_ctrl_p #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  TICK,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  output logic                  accept,
  output logic                  TX_OUT,
  output logic                  busy
);
  import uart_pkg::*;

  uart_state_e state;
  logic par_en_q, stop2_q, parity_q;
  logic dout, last, final_stop, capture, shift, first;

  assign final_stop = (state == S_STOP2) || (state == S_STOP1 && !stop2_q);
  assign capture    = TICK && Data_Valid && (state == S_IDLE || final_stop);
  assign accept     = capture && !RST;
  assign first      = (state == S_START);
  assign shift      = TICK && (first || (state == S_DATA && !last));

  uart_tx_shreg #(.DATA_WIDTH(DATA_WIDTH)) u_shreg (
    .CLK  (CLK),
    .RST  (RST),
    .load (capture),
    .shift(shift),
    .first(first),
    .din  (P_DATA),
    .dout (dout),
    .last (last)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      TX_OUT   <= 1'b1;
      busy     <= 1'b0;
      par_en_q <= 1'b0;
      stop2_q  <= 1'b0;
      parity_q <= 1'b0;
    end else begin
      if (capture) begin
        par_en_q <= PAR_EN;
        stop2_q  <= STOP2;
        parity_q <= par_bit(16'(P_DATA), PAR_TYP);
      end
      if (TICK) begin
        case (state)
          S_IDLE: if (capture) begin
            state  <= S_START;
            TX_OUT <= 1'b0;
            busy   <= 1'b1;
          end
          S_START: begin
            state  <= S_DATA;
            TX_OUT <= dout;
          end
          S_DATA: begin
            if (!last) begin
              TX_OUT <= dout;
            end else if (par_en_q) begin
              state  <= S_PARITY;
              TX_OUT <= parity_q;
            end else begin
              state  <= S_STOP1;
              TX_OUT <= 1'b1;
            end
          end
          S_PARITY: begin
            state  <= S_STOP1;
            TX_OUT <= 1'b1;
          end
          S_STOP1, S_STOP2: begin
            if (state == S_STOP1 && stop2_q) begin
              state  <= S_STOP2;
              TX_OUT <= 1'b1;
            end else if (capture) begin
              // Back-to-back: start bit follows the stop bit with no idle gap.
              state  <= S_START;
              TX_OUT <= 1'b0;
            end else begin
              state  <= S_IDLE;
              TX_OUT <= 1'b1;
              busy   <= 1'b0;
            end
          end
          default: begin
            state  <= S_IDLE;
            TX_OUT <= 1'b1;
            busy   <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_ctrl_p.sv
// Scoreboard bench: stimulus queues hand-written bit strings, per-instance monitors sample each bit period.
module tb_uart_tx_ctrl_p;
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       TICK;
  logic [1:0] tcnt = 2'd0;
  logic [7:0] pd8 = 8'h00;
  logic [4:0] pd5 = 5'h00;
  logic [8:0] pd9 = 9'h000;
  logic [2:0] dv = 3'b000;
  logic       pen = 1'b0, ptyp = 1'b0, st2 = 1'b0;
  logic [2:0] acc_v, tx_v, busy_v;

  int n_chk = 0, n_fail = 0;
  int busy_cnt = 0, acc_cnt = 0;
  bit track = 0, drop_seen = 0;
  string exp_q[3][$];

  always #5 CLK = ~CLK;
  always @(posedge CLK) tcnt <= tcnt + 2'd1;
  assign TICK = (tcnt == 2'd3);

  uart_tx_ctrl_p #(.DATA_WIDTH(8)) dut8 (
    .CLK(CLK), .RST(RST), .TICK(TICK), .P_DATA(pd8), .Data_Valid(dv[0]),
    .PAR_EN(pen), .PAR_TYP(ptyp), .STOP2(st2),
    .accept(acc_v[0]), .TX_OUT(tx_v[0]), .busy(busy_v[0]));
  uart_tx_ctrl_p #(.DATA_WIDTH(5)) dut5 (
    .CLK(CLK), .RST(RST), .TICK(TICK), .P_DATA(pd5), .Data_Valid(dv[1]),
    .PAR_EN(pen), .PAR_TYP(ptyp), .STOP2(st2),
    .accept(acc_v[1]), .TX_OUT(tx_v[1]), .busy(busy_v[1]));
  uart_tx_ctrl_p #(.DATA_WIDTH(9)) dut9 (
    .CLK(CLK), .RST(RST), .TICK(TICK), .P_DATA(pd9), .Data_Valid(dv[2]),
    .PAR_EN(pen), .PAR_TYP(ptyp), .STOP2(st2),
    .accept(acc_v[2]), .TX_OUT(tx_v[2]), .busy(busy_v[2]));

  // Monitors: a bit is sampled on the last cycle of its period (the TICK cycle).
  for (genvar g = 0; g < 3; g++) begin : g_mon
    string cur;
    int    pos;
    bit    act;
    initial begin
      act = 0;
      pos = 0;
      forever begin
        @(negedge CLK);
        if (RST) begin
          act = 0;
        end else if (TICK) begin
          if (!act && tx_v[g] === 1'b0) begin
            if (exp_q[g].size() == 0) begin
              n_chk++;
              n_fail++;
              $display("FAIL unexpected_frame inst%0d: start bit seen, none expected", g);
            end else begin
              cur = exp_q[g].pop_front();
              act = 1;
              pos = 0;
            end
          end
          if (act) begin
            n_chk++;
            if ({tx_v[g], busy_v[g]} !== {(cur[pos] == 8'h31), 1'b1}) begin
              n_fail++;
              $display("FAIL frame_bit inst%0d frame %s bit %0d: tx/busy=%b%b expected %b1",
                       g, cur, pos, tx_v[g], busy_v[g], (cur[pos] == 8'h31));
            end
            pos++;
            if (pos == cur.len()) act = 0;
          end
        end
      end
    end
  end

  initial forever begin
    @(negedge CLK);
    if (busy_v[0]) busy_cnt++;
    if (acc_v[0])  acc_cnt++;
    if (track && !busy_v[0]) drop_seen = 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Returns just after the capturing posedge.
  task automatic wait_acc(input int k, input string tag);
    int n = 0;
    while (n < 200) begin
      @(negedge CLK);
      if (acc_v[k]) break;
      n++;
    end
    if (n >= 200) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_accept_timeout: no accept within 200 cycles, expected one", tag);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_idle(input int k, input string tag);
    int n = 0;
    while (n < 400) begin
      @(negedge CLK);
      if (!busy_v[k]) break;
      n++;
    end
    if (n >= 400) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_idle_timeout: busy still high after 400 cycles, expected low", tag);
    end
  endtask

  task automatic send8(input logic [7:0] d, input logic p_en, input logic p_typ,
                       input logic s2, input string exp, input string tag);
    exp_q[0].push_back(exp);
    pd8 = d; pen = p_en; ptyp = p_typ; st2 = s2; dv[0] = 1'b1;
    wait_acc(0, tag);
    dv[0] = 1'b0;
    pd8 = ~d;
  endtask

  initial begin
    bit early;
    // Reset with Data_Valid high across a TICK: no accept allowed.
    dv[0] = 1'b1;
    early = 0;
    repeat (6) begin
      @(negedge CLK);
      if (acc_v[0]) early = 1;
    end
    chk("reset_outputs", {29'd0, tx_v}, 32'h7);
    chk("reset_busy", {29'd0, busy_v}, 32'h0);
    chk("reset_no_accept", {31'd0, early}, 32'h0);
    @(posedge CLK); #1;
    dv[0] = 1'b0;
    RST = 1'b0;

    // 0xA5, no parity, one stop: 10 periods of 4 cycles.
    busy_cnt = 0; acc_cnt = 0;
    send8(8'hA5, 1'b0, 1'b0, 1'b0, "0101001011", "a5");
    wait_idle(0, "a5");
    chk("a5_busy_cycles", busy_cnt, 40);
    chk("a5_accept_pulses", acc_cnt, 1);

    send8(8'h07, 1'b1, 1'b0, 1'b0, "01110000011", "p07_even");
    wait_idle(0, "p07_even");
    send8(8'h07, 1'b1, 1'b1, 1'b0, "01110000001", "p07_odd");
    wait_idle(0, "p07_odd");
    send8(8'h07, 1'b1, 1'b0, 1'b1, "011100000111", "p07_stop2");
    wait_idle(0, "p07_stop2");
    pen = 1'b0; ptyp = 1'b0; st2 = 1'b0;

    // Back-to-back: Data_Valid stays high, 0x22 presented on the 0x11 accept.
    exp_q[0].push_back("0100010001");
    exp_q[0].push_back("0010001001");
    pd8 = 8'h11; dv[0] = 1'b1;
    wait_acc(0, "b2b1");
    pd8 = 8'h22; drop_seen = 0; track = 1;
    wait_acc(0, "b2b2");
    track = 0; dv[0] = 1'b0;
    chk("b2b_busy_no_drop", {31'd0, drop_seen}, 32'h0);
    wait_idle(0, "b2b");

    // Reset during data bit 3 of 0x3C, then a clean 0xC3 frame.
    send8(8'h3C, 1'b0, 1'b0, 1'b0, "0001111001", "rst_frame");
    repeat (17) @(posedge CLK);
    #1 RST = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("rst_mid_tx", {31'd0, tx_v[0]}, 32'h1);
    chk("rst_mid_busy", {31'd0, busy_v[0]}, 32'h0);
    send8(8'hC3, 1'b0, 1'b0, 1'b0, "0110000111", "after_rst");
    wait_idle(0, "after_rst");

    // Data_Valid raised right after a TICK; config and data toggled mid-frame.
    do @(negedge CLK); while (!TICK);
    @(posedge CLK); #1;
    exp_q[0].push_back("00101101001");
    pd8 = 8'h5A; pen = 1'b1; ptyp = 1'b0; st2 = 1'b0; dv[0] = 1'b1;
    early = 0;
    repeat (3) begin
      @(negedge CLK);
      if (acc_v[0]) early = 1;
    end
    chk("no_accept_between_ticks", {31'd0, early}, 32'h0);
    wait_acc(0, "midframe");
    dv[0] = 1'b0;
    repeat (12) begin
      @(posedge CLK); #1;
      pd8 = 8'($urandom); pen = ~pen; ptyp = ~ptyp; st2 = ~st2;
    end
    wait_idle(0, "midframe");
    pen = 1'b0; ptyp = 1'b0; st2 = 1'b0;

    // Narrow and wide builds, all ones.
    exp_q[1].push_back("0111111");
    exp_q[2].push_back("01111111111");
    pd5 = 5'h1F; pd9 = 9'h1FF; dv[1] = 1'b1; dv[2] = 1'b1;
    wait_acc(1, "dw5");
    dv[1] = 1'b0; dv[2] = 1'b0;
    wait_idle(1, "dw5");
    wait_idle(2, "dw9");

    repeat (8) @(posedge CLK);
    for (int k = 0; k < 3; k++) chk($sformatf("frames_pending_inst%0d", k), exp_q[k].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_ctrl_p.md
# uart_tx_ctrl_p

Parametrised UART transmit controller: the next generation of the UART TX path. It takes a parallel word through a valid/accept handshake, serialises it LSB-first, and appends an optional even/odd parity bit and one or two stop bits. All timing is paced by an external bit-rate enable. Unlike the previous TX FSM, it integrates the serializer, parity and output mux, latches per-frame configuration, and supports back-to-back frames with no idle bit between them.

## Interface
- DATA_WIDTH, 8, data bits per frame; legal range 5..9.
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- TICK  in  1  bit-rate enable, one CLK cycle wide. One bit period is the interval between consecutive TICKs.
- P_DATA  in  DATA_WIDTH  word to transmit.
- Data_Valid  in  1  source holds it high until accepted.
- PAR_EN  in  1  1 = append parity bit.
- PAR_TYP  in  1  0 = even, 1 = odd.
- STOP2  in  1  1 = two stop bits, 0 = one.
- accept  out  1  combinational pulse marking the capture cycle; the source may change P_DATA and Data_Valid in the following cycle.
- TX_OUT  out  DATA_WIDTH-independent 1  serial line, registered, idles high.
- busy  out  1  registered; high while a frame is on the line.

## Operation
- States: IDLE, START, DATA, PARITY, STOP1, STOP2.
- Capture condition: `TICK & Data_Valid & (state==IDLE | (state is final stop bit))`.
  - The final stop bit is STOP1 when the frame's STOP2=0, otherwise STOP2.
  - On capture, `accept`=1 and the following are latched: P_DATA, PAR_EN, PAR_TYP, STOP2.
  - The parity bit is computed once at capture: XOR of all data bits, inverted when PAR_TYP=1.
- Transitions. All advance only on cycles with TICK=1; state holds otherwise.
  - IDLE→START on capture.
  - START→DATA, with bit counter cleared to 0.
  - DATA: the counter increments on each TICK. When counter==DATA_WIDTH-1: →PARITY if latched PAR_EN, else →STOP1.
  - PARITY→STOP1.
  - STOP1→STOP2 if latched STOP2=1.
  - Final stop bit → START on capture (back-to-back), else → IDLE.
- TX_OUT per state: IDLE 1, START 0, DATA shift_reg[0] (LSB first), PARITY latched parity, STOP1/STOP2 1.
- Configuration inputs and P_DATA changing mid-frame have no effect on the frame in progress.
- Data_Valid outside a capture condition is ignored; no data is lost, since accept stays low.
- Bit counter width is $clog2(DATA_WIDTH). It never exceeds DATA_WIDTH-1.

## Timing
- Reset values: state IDLE, TX_OUT=1, busy=0, counter=0, shift register 0, latched config 0. accept=0 while RST=1.
- Reset mid-frame: the frame is abandoned. From the next cycle TX_OUT=1 and busy=0; a capture is possible at the first TICK after RST deasserts.
- Bit boundaries: each bit starts the cycle after a TICK and ends on the cycle of the next TICK inclusive. The first bit therefore spans a full period, because capture only occurs on a TICK.
- TX_OUT and busy are registered and change the cycle after the TICK that causes the transition.
- busy=1 from the cycle after capture through the final stop TICK. It drops the cycle after that TICK only when no back-to-back capture occurs.
- Frame length in TICK periods: 1 + DATA_WIDTH + PAR_EN + 1 + STOP2.
  - Example: DATA_WIDTH=8, no parity, 1 stop = 10 periods.
  - Example: DATA_WIDTH=9, parity, 2 stop = 13 periods.
- Back-to-back: the stop bit of frame N is followed immediately by the start bit of frame N+1. busy stays high throughout.
- TICK on consecutive cycles is legal, giving 1-cycle bits.

## Structure
- Package uart_pkg:
  - 3-bit state encoding localparams: IDLE=0, START=1, DATA=2, PARITY=3, STOP1=4, STOP2=5.
  - PAR_EVEN/PAR_ODD constants.
  - Shared by future uart_rx_ctrl_p.
- One sub-module, uart_tx_shreg: DATA_WIDTH shift register plus bit counter.
  - Ports: load, shift, din, dout bit, last flag (counter==DATA_WIDTH-1).
  - Parity XOR, next-state logic and the output mux stay in the top level.

## Test plan
- DATA_WIDTH=8, P_DATA=0xA5, PAR_EN=0, STOP2=0, TICK every 4 cycles:
  - TX_OUT sequence per period: 0,1,0,1,0,0,1,0,1,1.
  - busy high for 40 cycles, accept one pulse.
- P_DATA=0x07, PAR_EN=1, PAR_TYP=0 → parity bit 1.
  - Same with PAR_TYP=1 → parity bit 0.
  - STOP2=1 → two high stop periods; frame 12 periods.
- Data_Valid held high with 0x11 then 0x22 presented on accept: second start bit directly follows the first stop bit, and busy never drops between frames.
- DATA_WIDTH=5 and DATA_WIDTH=9 builds, P_DATA all ones: exactly 5 or 9 data periods, respectively, at TX_OUT=1.
- RST pulsed during data bit 3: next cycle TX_OUT=1 and busy=0; the following capture sends a clean complete frame.
- Data_Valid raised between TICKs, and P_DATA/PAR_EN toggled mid-frame:
  - No capture before the next TICK.
  - The in-flight frame's bits and parity are unchanged.
